// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared state encoding and default widths for the tick timer
package tick_timer_pkg;

    localparam int CNT_W_DEF = 8;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/tick_timer_edge_sync.sv
// edge_sync: synchronizes an asynchronous level and emits a registered one-cycle pulse per rising edge
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   rise_d;

    assign rise_d     = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign rise_pulse = rise_q;

    // shift the async level through the synchronizer, remember the last synced value, register the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= rise_d;
        end
    end

endmodule

// File: rtl/tick_timer.sv
// tick_timer: counts down a loaded number of synchronized ticks and pulses done on expiry
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             tick,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_async    (tick_in),
        .rise_pulse (tick)
    );

    assign remaining = rem_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;

    // load wins over a same-cycle tick; done is masked while already high so it never lasts two cycles
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (load) begin
            rem_d   = load_val;
            state_d = (load_val != '0) ? RUN : IDLE;
            done_d  = (load_val == '0) & ~done_q;
        end else if (state_q == RUN && tick && enable) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = ~done_q;
            end
        end
    end

    // state, count and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: table, directed and randomized checks of tick_timer against a behavioural model
module tb_tick_timer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       load = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       tick, busy, done;
    logic [7:0] remaining;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_rem;
    logic       m_busy, m_done, m_tick;
    logic       hist[$];

    typedef struct {
        logic       ld;
        logic [7:0] val;
        logic       en;
        logic       ti;
        logic [7:0] rem;
        logic       bsy;
        logic       dn;
        logic       tk;
    } vec_t;

    vec_t tbl[12];

    tick_timer #(.CNT_W(8), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .load      (load),
        .load_val  (load_val),
        .enable    (enable),
        .tick      (tick),
        .remaining (remaining),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem  = 8'd0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_tick = 1'b0;
        hist   = {};
        for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
    endtask

    // hist[k] is tick_in as sampled k edges ago; a tick appears S edges after the edge that first saw it high
    task automatic model_step();
        logic nd;
        nd = 1'b0;
        if (load) begin
            m_rem  = load_val;
            m_busy = (load_val != 0);
            nd     = (load_val == 0);
        end else if (m_busy && m_tick && enable) begin
            m_rem = m_rem - 8'd1;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                nd     = 1'b1;
            end
        end
        m_done = nd & ~m_done;
        hist.push_front(tick_in);
        void'(hist.pop_back());
        m_tick = hist[S] & ~hist[S+1];
    endtask

    task automatic cmp_model();
        chk("model_rem", remaining, m_rem);
        chk("model_busy", 8'(busy), 8'(m_busy));
        chk("model_done", 8'(done), 8'(m_done));
        chk("model_tick", 8'(tick), 8'(m_tick));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        cmp_model();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rem"}, remaining, 8'd0);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_done"}, 8'(done), 8'd0);
        chk({tag, "_tick"}, 8'(tick), 8'd0);
    endtask

    task automatic apply_reset(input logic ti);
        tick_in = ti;
        load    = 1'b0;
        enable  = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        #1;
        chk_zero("async_rst");
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic pulse();
        tick_in = 1'b1;
        cycle();
        cycle();
        tick_in = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'd3, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

        model_reset();
        cycle();
        cycle();
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            load     = tbl[i].ld;
            load_val = tbl[i].val;
            enable   = tbl[i].en;
            tick_in  = tbl[i].ti;
            cycle();
            chk($sformatf("tbl%0d_rem", i), remaining, tbl[i].rem);
            chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tbl[i].bsy));
            chk($sformatf("tbl%0d_done", i), 8'(done), 8'(tbl[i].dn));
            chk($sformatf("tbl%0d_tick", i), 8'(tick), 8'(tbl[i].tk));
        end

        apply_reset(1'b0);
        for (int c = 0; c <= 20; c++) begin
            tick_in = (c >= 10 && c < 16);
            cycle();
            chk($sformatf("lat_tick_c%0d", c + 1), 8'(tick), 8'(c + 1 == 13));
        end

        enable   = 1'b1;
        load     = 1'b1;
        load_val = 8'd5;
        cycle();
        load = 1'b0;
        chk("pause_rem0", remaining, 8'd5);
        enable = 1'b0;
        pulse();
        chk("pause_rem1", remaining, 8'd5);
        pulse();
        chk("pause_rem2", remaining, 8'd5);
        enable = 1'b1;
        pulse();
        chk("pause_rem3", remaining, 8'd4);

        load     = 1'b1;
        load_val = 8'd3;
        cycle();
        load = 1'b0;
        pulse();
        chk("prio_rem2", remaining, 8'd2);
        tick_in = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("prio_tick", 8'(tick), 8'd1);
        load     = 1'b1;
        load_val = 8'd7;
        cycle();
        load    = 1'b0;
        tick_in = 1'b0;
        chk("prio_rem", remaining, 8'd7);
        chk("prio_busy", 8'(busy), 8'd1);
        chk("prio_done", 8'(done), 8'd0);
        cycle();
        chk("prio_hold", remaining, 8'd7);

        load     = 1'b1;
        load_val = 8'd4;
        cycle();
        load = 1'b0;
        chk("abort_rem", remaining, 8'd4);
        #2;
        apply_reset(1'b1);
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk("abort_done", 8'(done), 8'd0);
            chk($sformatf("rel_tick_c%0d", c + 1), 8'(tick), 8'(c + 1 == S + 1));
        end

        tick_in = 1'b0;
        for (int i = 0; i < 500; i++) begin
            load     = ($urandom_range(7) == 0);
            load_val = 8'($urandom_range(6));
            enable   = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0) tick_in = ~tick_in;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter CNT_W, default 8, width of the countdown value.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on tick_in; legal values 2..4.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tick_in  input  1  slow square wave from the divided-clock generator, asynchronous to clk.
REQ-006 load  input  1  one-cycle request: capture load_val and start counting.
REQ-007 load_val  input  CNT_W  number of ticks to count down.
REQ-008 enable  input  1  when low, countdown pauses and ticks are ignored by the counter.
REQ-009 tick  output  1  one-cycle pulse per rising edge of tick_in.
REQ-010 remaining  output  CNT_W  ticks left before expiry.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse on expiry.

Function
REQ-013 The block SHALL pass tick_in through SYNC_STAGES flops, then one edge-history flop; tick = sync_out & ~history.
REQ-014 The latency from a tick_in rising edge to tick high SHALL be SYNC_STAGES+1 clk cycles, with tick high for exactly one cycle.
REQ-015 Falling edges of tick_in SHALL produce no tick.
REQ-016 tick SHALL be generated regardless of the state, enable, or load inputs.
REQ-017 The FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-018 load in any state SHALL set remaining <= load_val on the next edge; the next state SHALL be RUN if load_val != 0, else IDLE with done pulsed that same next cycle.
REQ-019 In RUN, tick & enable & ~load SHALL decrement remaining by 1.
REQ-020 When remaining==1, that decrement SHALL set remaining to 0, pulse done in the following cycle, and return the FSM to IDLE.
REQ-021 A simultaneous load and tick SHALL give load priority, with that tick discarded.
REQ-022 In RUN with enable=0, remaining SHALL hold and ticks SHALL be lost, not queued.
REQ-023 In IDLE, ticks SHALL NOT change remaining; remaining holds its last value and never underflows or wraps.
REQ-024 done SHALL never be high for two consecutive cycles.
REQ-025 done SHALL be a registered output, with no combinational path from inputs.

Reset
REQ-026 While rst_n=0 the block SHALL hold the following reset values:
- synchronizer and history flops = 0
- state = IDLE
- remaining = 0
- tick, busy, done = 0
REQ-027 Reset asserted mid-RUN SHALL abort the count immediately with no done pulse.
REQ-028 If tick_in is high at reset release, exactly one tick SHALL be produced SYNC_STAGES+1 cycles after release.

Structure
REQ-029 State encoding (IDLE/RUN) and the default CNT_W SHALL live in the shared timer package.
REQ-030 The synchronizer and edge detector SHALL be one sub-module, edge_sync, with ports clk, rst_n, d_async, rise_pulse and parameter SYNC_STAGES.
REQ-031 The tick_timer top SHALL contain only the FSM and the counter.

Verification
REQ-032 Reset then tick_in rising at cycle 10, SYNC_STAGES=2 -> tick high only in cycle 13; no tick on the falling edge.
REQ-033 load_val=3 with enable=1, then 3 tick_in rising edges -> remaining steps 3,2,1,0; done pulses once; busy falls with done.
REQ-034 load_val=0 -> done pulses the next cycle; busy stays 0; remaining=0.
REQ-035 Running with remaining=5, enable=0 across 2 ticks, then enable=1 for 1 tick -> remaining steps 5,5,5,4.
REQ-036 load_val=7 issued in the same cycle as an internal tick while remaining=2 -> remaining=7, no decrement, no done.
REQ-037 rst_n dropped mid-count with remaining=4 -> all outputs 0 asynchronously; no done pulse after release.
